// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// Define MULDIV_DIV_EN to build the divide datapath; otherwise divides report illegal.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            illegal
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
`ifdef MULDIV_DIV_EN
        S_DIV,
`endif
        S_FIX,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_illegal;
    logic [XLEN-1:0]   r_result;
    logic [2:0]        r_op;
    logic              r_neg;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_mcand;

    logic              w_accept;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_sa;
    logic              w_sb;
    logic              w_res_neg;
    logic              w_early;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;
    logic [XLEN-1:0]   w_fix_res;

    assign w_accept   = start && !r_busy && !flush && (alu_op == 2'b10) && (funct7 == 7'b0000001);
    assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_sa       = w_a_signed && rs1[XLEN-1];
    assign w_sb       = w_b_signed && rs2[XLEN-1];
    assign w_mag_a    = w_sa ? -rs1 : rs1;
    assign w_mag_b    = w_sb ? -rs2 : rs2;
    // Remainders take the dividend's sign; products and quotients take sA^sB.
    assign w_res_neg  = (funct3[2] && funct3[1]) ? w_sa : (w_sa ^ w_sb);

    // Low half of the accumulator holds the unconsumed multiplier bits.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_prod     = r_neg ? -r_acc : r_acc;
    assign w_mul_res  = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

`ifdef MULDIV_DIV_EN
    logic [XLEN:0]     r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_dvs;
    logic              r_early;
    logic [XLEN-1:0]   r_early_res;

    logic              w_div_zero;
    logic              w_ovf;
    logic [XLEN-1:0]   w_early_res;
    logic [XLEN+1:0]   w_div_diff;
    logic [XLEN-1:0]   w_quo_res;
    logic [XLEN-1:0]   w_rem_res;

    assign w_div_zero  = (rs2 == '0);
    assign w_ovf       = !funct3[0] && (rs1 == MIN_NEG) && (rs2 == '1);
    assign w_early     = funct3[2] && (w_div_zero || w_ovf);
    assign w_early_res = w_div_zero ? (funct3[1] ? rs1 : '1) : (funct3[1] ? '0 : rs1);

    // Trial subtraction; the top bit is the borrow that decides restore.
    assign w_div_diff  = {r_rem, r_quo[XLEN-1]} - {2'b00, r_dvs};
    assign w_quo_res   = r_neg ? -r_quo : r_quo;
    assign w_rem_res   = r_neg ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
    assign w_fix_res   = r_early ? r_early_res : (r_op[2] ? (r_op[1] ? w_rem_res : w_quo_res) : w_mul_res);
`else
    assign w_early     = funct3[2];
    assign w_fix_res   = r_op[2] ? '0 : w_mul_res;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_result  <= '0;
            r_op      <= '0;
            r_neg     <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
`ifdef MULDIV_DIV_EN
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_early     <= 1'b0;
            r_early_res <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    if (w_accept) begin
                        r_op    <= funct3;
                        r_neg   <= w_res_neg;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_acc   <= {{XLEN{1'b0}}, w_mag_b};
                        r_mcand <= w_mag_a;
`ifdef MULDIV_DIV_EN
                        r_rem       <= '0;
                        r_quo       <= w_mag_a;
                        r_dvs       <= w_mag_b;
                        r_early     <= w_early;
                        r_early_res <= w_early_res;
`endif
                        if (w_early)
                            r_state <= S_FIX;
`ifdef MULDIV_DIV_EN
                        else if (funct3[2])
                            r_state <= S_DIV;
`endif
                        else
                            r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(XLEN-1)) begin
                            r_state <= S_FIX;
                            r_cnt   <= '0;
                        end
                    end
                end
`ifdef MULDIV_DIV_EN
                S_DIV: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (!w_div_diff[XLEN+1]) begin
                            r_rem <= w_div_diff[XLEN:0];
                            r_quo <= {r_quo[XLEN-2:0], 1'b1};
                        end else begin
                            r_rem <= {r_rem[XLEN-1:0], r_quo[XLEN-1]};
                            r_quo <= {r_quo[XLEN-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(XLEN-1)) begin
                            r_state <= S_FIX;
                            r_cnt   <= '0;
                        end
                    end
                end
`endif
                S_FIX: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_result <= w_fix_res;
`ifdef MULDIV_DIV_EN
                        r_illegal <= 1'b0;
`else
                        r_illegal <= r_op[2];
`endif
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = r_result;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: randomized ops checked against an arithmetic model,
// plus flush/reset abort, ignored starts and back-to-back issue.
module tb_muldiv_unit;
    localparam int XLEN = 32;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        illegal;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .funct3(funct3),
        .funct7(funct7), .rs1(rs1), .rs2(rs2), .flush(flush),
        .busy(busy), .done(done), .result(result), .illegal(illegal)
    );

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          lat;
        int          issue_cyc;
        int          busy_at;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   busy_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Reference: results straight from RV32M arithmetic rules.
    function automatic void model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        logic [63:0] p;
        int ia;
        int ib;
        ia  = a;
        ib  = b;
        ill = 1'b0;
        lat = XLEN + 2;
        r   = '0;
        case (f3)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
            3'd1: begin p = longint'(ia) * longint'(ib); r = p[63:32]; end
            3'd2: begin p = longint'(ia) * longint'({32'd0, b}); r = p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == 32'd0) begin
                    r = f3[1] ? a : 32'hFFFF_FFFF;
                    lat = 2;
                end else if (!f3[0] && a == MIN_NEG && b == 32'hFFFF_FFFF) begin
                    r = f3[1] ? 32'd0 : a;
                    lat = 2;
                end else begin
                    case (f3)
                        3'd4:    r = ia / ib;
                        3'd5:    r = a / b;
                        3'd6:    r = ia % ib;
                        default: r = a % b;
                    endcase
                end
`else
                r   = '0;
                ill = 1'b1;
                lat = 2;
`endif
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return MIN_NEG;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    // Monitor: pops the oldest expectation on every done pulse.
    always @(negedge clk) begin
        if (busy) busy_total <= busy_total + 1;
        if (done) begin
            if (sbq.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("result", result, mon_e.res);
                chk("illegal", 32'(illegal), 32'(mon_e.ill));
                chk("latency", 32'(cyc - mon_e.issue_cyc), 32'(mon_e.lat));
                chk("busy_cycles", 32'(busy_total - mon_e.busy_at), 32'(mon_e.lat - 1));
                chk("busy_in_done", 32'(busy), 32'd0);
                $display("txn f3=%0d rs1=%08h rs2=%08h result=%08h illegal=%0b lat=%0d",
                         mon_e.f3, mon_e.a, mon_e.b, result, illegal, cyc - mon_e.issue_cyc);
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        model(f3, a, b, e.res, e.ill, e.lat);
        e.issue_cyc = cyc;
        e.busy_at   = busy_total;
        e.f3 = f3;
        e.a  = a;
        e.b  = b;
        alu_op = 2'b10;
        funct7 = 7'b0000001;
        funct3 = f3;
        rs1    = a;
        rs2    = b;
        start  = 1'b1;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        issue(f3, a, b);
        wait_idle();
    endtask

    logic [2:0]  d_f3 [13] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4};
    logic [31:0] d_a  [13] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                               32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000,
                               32'h8000_0000, 32'd9};
    logic [31:0] d_b  [13] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                               32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF,
                               32'hFFFF_FFFF, 32'd3};

    logic [31:0] prev_res;
    logic        prev_ill;
    int          prev_lat;

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; flush = 1'b0; alu_op = 2'b00;
        funct3 = 3'd0; funct7 = 7'd0; rs1 = '0; rs2 = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) run_op(d_f3[i], d_a[i], d_b[i]);

        // Abort by flush: no done, previous result retained.
        model(3'd0, 32'd3, 32'd5, prev_res, prev_ill, prev_lat);
        run_op(3'd0, 32'd3, 32'd5);
        issue(3'd0, 32'd7, 32'd9);
        repeat (8) @(negedge clk);
        sbq.delete();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        chk("flush_result_held", result, prev_res);

        // Abort by reset: result cleared.
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) @(negedge clk);
        sbq.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        repeat (40) @(negedge clk);

        // Back-to-back: second op issued in the done cycle of the first.
        issue(3'd0, 32'd7, 32'hFFFF_FFFD);
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_seen", 32'(done), 32'd1);
        issue(3'd3, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        chk("b2b_accepted", 32'(busy), 32'd1);
        wait_idle();

        // Starts that must be ignored.
        issue(3'd0, 32'd11, 32'd13);
        repeat (3) @(negedge clk);
        funct3 = 3'd5; rs1 = 32'd99; rs2 = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        alu_op = 2'b10; funct7 = 7'd0; funct3 = 3'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignore_funct7", 32'(busy), 32'd0);
        alu_op = 2'b00; funct7 = 7'b0000001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignore_aluop", 32'(busy), 32'd0);
        alu_op = 2'b10; flush = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_beats_start", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);

        for (int i = 0; i < 80; i++) run_op(3'($urandom_range(0, 7)), pick(), pick());

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised, multi-cycle RV32M multiply/divide execution unit that sits beside the single-cycle ALU in the execute stage. It decodes the same `alu_op`/`funct3`/`funct7` fields the ALU control path consumes, and claims R-type ops with `funct7 = 0000001`. Claimed ops are computed iteratively with a start/busy/done handshake, and the pipeline stalls on `busy`. Operand width is generalised through `XLEN`.

## Interface
- `XLEN`, 32: operand/result width; must be even and ≥ 8.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; qualified by decode and `!busy`.
- `alu_op` input 2: main-decoder ALU op class.
- `funct3` input 3: instruction funct3.
- `funct7` input 7: instruction funct7.
- `rs1` input XLEN: operand A.
- `rs2` input XLEN: operand B.
- `flush` input 1: abort the in-flight op (branch mispredict or trap).
- `busy` output 1: unit occupied; stall request to hazard unit.
- `done` output 1: one-cycle pulse; `result` valid.
- `result` output XLEN: registered result, held until the next `done`.
- `illegal` output 1: registered with `done`; op not supported in this build.

## Operation
- Accept when `start && !busy && alu_op==2'b10 && funct7==7'b0000001`. Any other `start` is ignored and no state changes.
- `funct3`: 000 MUL (low XLEN), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- On accept, latch the op and convert operands to magnitudes according to signedness. Record the result sign:
  - multiply sign = sA XOR sB.
  - quotient sign = sA XOR sB.
  - remainder sign = sA.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE→MUL or IDLE→DIV on accept.
  - MUL/DIV run exactly XLEN iterations, counted by a log2(XLEN)+1-bit counter, then go to FIX.
  - FIX applies two's-complement negation if the sign requires it, selects high/low or quotient/remainder, and loads `result`. FIX→DONE.
  - DONE→IDLE.
- Multiply: shift-add over a 2·XLEN accumulator, one multiplier bit per cycle.
- Divide: restoring, one quotient bit per cycle over an (XLEN+1)-bit partial remainder.
- Early-out: IDLE→FIX directly, no iteration, in two cases:
  - Divide by zero: quotient = all ones; remainder = `rs1` (unmodified, signed or unsigned).
  - Signed overflow (DIV/REM with `rs1 = 1<<(XLEN-1)` and `rs2 = -1`): quotient = `rs1`; remainder = 0.
- `illegal` = 0 for all supported ops.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `illegal`=0, counter 0.
- Accept on edge k.
  - Latency L = XLEN+2 for iterative ops (34 at XLEN=32) and L = 2 for early-out.
  - `busy`=1 in cycles k+1 … k+L−1.
  - `done`=1 only in cycle k+L, with `busy`=0.
- A new `start` in the `done` cycle is accepted (back-to-back ops). `start` while `busy` is ignored and never queued.
- `flush` or `rst` while busy: the next edge returns to IDLE with `busy`=0. No `done` follows, and `result` keeps its previous value (`rst` clears it to 0).
- `flush` and `start` in the same IDLE cycle: `flush` wins and nothing is accepted.
- `result` and `illegal` change only on the `done` edge (or on reset).

## Configuration
- `MULDIV_DIV_EN` defined: full RV32M, as described above.
- `MULDIV_DIV_EN` undefined:
  - Divide datapath and DIV state are not compiled.
  - `funct3[2]=1` ops are still accepted but take the early-out path (L = 2), with `result`=0 and `illegal`=1 in the `done` cycle.
  - Multiply ops are unchanged.

## Test plan
- MUL, rs1=7, rs2=0xFFFFFFFD (−3), XLEN=32 → `done` 34 cycles after accept, `result`=0xFFFFFFEB, `busy` high 33 cycles.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULH same operands → 0x00000000; MULHSU −1×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with `done` 2 cycles after accept; DIV 0x80000000/−1 → 0x80000000 and REM → 0.
- Start MUL, assert `flush` at cycle 10 → `busy` low next cycle, no `done`, prior `result` held. Repeat with `rst` → `result`=0. Then a back-to-back MUL issued in the `done` cycle completes correctly.
- Build without `MULDIV_DIV_EN`: DIV 9/3 → `done` at 2 cycles, `illegal`=1, `result`=0. ADD-class `start` (funct7=0) → ignored, `busy` stays 0.
